// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg -- shared types and constants for the six-digit BCD counter.
//   NUM_DIGITS : number of BCD digits in the counter and on the display
//   bcd_t      : one BCD digit (0..9 held in 4 bits)
//   seg_t      : one seven-segment pattern, active-low, {dp,g,f,e,d,c,b,a}
//   SEG_0..9   : segment patterns for each decimal digit, decimal point off
//   SEG_BLANK  : all segments off
// -----------------------------------------------------------------------------
package top_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/top_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode -- BCD digit to active-low seven-segment pattern.
//   i_digit : BCD digit, 0..9
//   o_seg   : segment pattern {dp,g,f,e,d,c,b,a}, active-low, dp off
// Codes 10..15 never occur in the counter; they decode to blank.
// -----------------------------------------------------------------------------
module seg7_decode
  import top_pkg::*;
(
  input  bcd_t i_digit,
  output seg_t o_seg
);

  always_comb begin
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top -- six-digit BCD up/down counter with prescaled tick and 7-seg display.
//   TICK_DIV   : clock cycles per count tick (>= 2)
//   ADC_CLK_10 : clock, rising edge
//   KEY[0]     : reset, asynchronous, active-low
//   KEY[1]     : clear pushbutton, active-low, synchronized, level-sensitive
//   SW[0]      : run (1 = count, 0 = hold); SW[1] : direction (0 up, 1 down)
//   SW[9:2]    : unused
//   LEDR       : {run & ~clear, direction, digit1, digit0}
//   HEX0..HEX5 : digits 0..5 (HEX0 least significant), active-low segments
// Build option: define TOP_BLANK_LEADING_ZERO_EN to blank leading zeros on
// HEX5..HEX1; HEX0 always shows its digit.
// -----------------------------------------------------------------------------
module top
  import top_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       ADC_CLK_10,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);

  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  logic                       w_rst_n;
  logic                       w_run;
  logic                       w_down;
  logic                       w_clear;
  logic                       w_tick;
  logic                       w_unused_sw;
  logic [1:0]                 r_sync;
  logic [PW-1:0]              r_presc;
  bcd_t [NUM_DIGITS-1:0]      r_digits;
  bcd_t [NUM_DIGITS-1:0]      w_digits_step;
  seg_t [NUM_DIGITS-1:0]      w_seg;
  logic [NUM_DIGITS-1:0]      w_blank;

  assign w_rst_n     = KEY[0];
  assign w_run       = SW[0];
  assign w_down      = SW[1];
  assign w_unused_sw = ^SW[9:2];

  // Two-flop synchronizer for the clear button; flops reset to 1 so clear is
  // inactive coming out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others (r_sync[1] gets the old r_sync[0]).
  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], KEY[1]};
  end

  assign w_clear = ~r_sync[1];
  assign w_tick  = w_run && (r_presc == PRESC_MAX);

  // Prescaler: runs only while run is set, holds otherwise.
  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n)     r_presc <= '0;
    else if (w_clear) r_presc <= '0;
    else if (w_run)   r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  // One-step increment/decrement with the carry (or borrow) rippling through
  // every digit in the same cycle. A digit at its limit wraps and passes the
  // carry on; the first digit that does not wrap absorbs it.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin : step_blk
    logic v_carry;
    w_digits_step = r_digits;
    v_carry       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_carry) begin
        if (!w_down) begin
          if (r_digits[i] == 4'd9) w_digits_step[i] = 4'd0;
          else begin
            w_digits_step[i] = r_digits[i] + 4'd1;
            v_carry          = 1'b0;
          end
        end else begin
          if (r_digits[i] == 4'd0) w_digits_step[i] = 4'd9;
          else begin
            w_digits_step[i] = r_digits[i] - 4'd1;
            v_carry          = 1'b0;
          end
        end
      end
    end
  end

  // Clear dominates a coincident tick.
  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n)     r_digits <= '0;
    else if (w_clear) r_digits <= '0;
    else if (w_tick)  r_digits <= w_digits_step;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .i_digit (r_digits[g]),
      .o_seg   (w_seg[g])
    );
  end

`ifdef TOP_BLANK_LEADING_ZERO_EN
  // A digit blanks when it and every more significant digit are zero.
  always_comb begin : blank_blk
    logic v_all_zero;
    w_blank    = '0;
    v_all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_all_zero = v_all_zero && (r_digits[i] == 4'd0);
      w_blank[i] = v_all_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign HEX0 = w_blank[0] ? SEG_BLANK : w_seg[0];
  assign HEX1 = w_blank[1] ? SEG_BLANK : w_seg[1];
  assign HEX2 = w_blank[2] ? SEG_BLANK : w_seg[2];
  assign HEX3 = w_blank[3] ? SEG_BLANK : w_seg[3];
  assign HEX4 = w_blank[4] ? SEG_BLANK : w_seg[4];
  assign HEX5 = w_blank[5] ? SEG_BLANK : w_seg[5];

  assign LEDR = {w_run & ~w_clear, w_down, r_digits[1], r_digits[0]};

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top -- directed bench for top with TICK_DIV = 4 (one tick per 4 clocks).
// Compile with TOP_BLANK_LEADING_ZERO_EN defined to exercise leading-zero
// blanking; expected display values follow the same build option.
// -----------------------------------------------------------------------------
module tb_top;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [47:0] hex_all;

  int total = 0;
  int bad   = 0;

  top #(.TICK_DIV(4)) dut (
    .ADC_CLK_10 (clk),
    .KEY        (key),
    .SW         (sw),
    .LEDR       (ledr),
    .HEX0       (hex0),
    .HEX1       (hex1),
    .HEX2       (hex2),
    .HEX3       (hex3),
    .HEX4       (hex4),
    .HEX5       (hex5)
  );

  always #5 clk = ~clk;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  // Expected six-digit display for a count written as 24'hDDDDDD.
  function automatic logic [47:0] exp_hex(input logic [23:0] bcd);
    logic [47:0] r;
    logic [7:0]  s;
    logic        hi_zero;
    r       = '0;
    hi_zero = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      s       = enc(bcd[i*4 +: 4]);
      hi_zero = hi_zero && (bcd[i*4 +: 4] == 4'd0);
`ifdef TOP_BLANK_LEADING_ZERO_EN
      if (i > 0 && hi_zero) s = 8'hFF;
`endif
      r[i*8 +: 8] = s;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    key = 2'b10;
    sw  = '0;
    #22;
    check("hex_in_reset", hex_all, exp_hex(24'h000000));
    key = 2'b11;
    step(100);
    check("hex_after_reset", hex_all, exp_hex(24'h000000));
    check("ledr_after_reset", ledr, 10'h000);

    // Up count; SW[9:2] set high to show they are ignored.
    sw = 10'b1111_1111_01;
    step(3);
    check("no_tick_before_div", hex_all, exp_hex(24'h000000));
    step(1);
    check("first_tick", hex_all, exp_hex(24'h000001));
    check("ledr_count1", ledr, 10'h201);
    step(4);
    check("second_tick", hex_all, exp_hex(24'h000002));
    step(32);
    check("carry_9_to_10", hex_all, exp_hex(24'h000010));
    step(40);
    check("count_20", hex_all, exp_hex(24'h000020));
    step(80);
    check("count_40", hex_all, exp_hex(24'h000040));
    check("ledr_count40", ledr, 10'h240);

    // Clear held low across several tick periods.
    key = 2'b01;
    step(2);
    check("ledr_run_masked", ledr[9], 1'b0);
    step(1);
    check("clear_within_3", hex_all, exp_hex(24'h000000));
    step(8);
    check("clear_held", hex_all, exp_hex(24'h000000));
    key = 2'b11;
    step(5);
    check("post_clear_no_tick", hex_all, exp_hex(24'h000000));
    step(1);
    check("post_clear_tick", hex_all, exp_hex(24'h000001));

    // Down count through zero, then straight back up.
    sw = 10'b0000_0000_11;
    step(4);
    check("down_to_0", hex_all, exp_hex(24'h000000));
    step(4);
    check("down_wrap", hex_all, exp_hex(24'h999999));
    check("ledr_down_wrap", ledr, 10'h399);
    sw = 10'b0000_0000_01;
    step(4);
    check("up_wrap", hex_all, exp_hex(24'h000000));

    // Asynchronous reset pulse mid-count.
    step(20);
    check("before_async_rst", hex_all, exp_hex(24'h000005));
    step(2);
    #2;
    key = 2'b10;
    #1;
    check("async_rst_immediate", hex_all, exp_hex(24'h000000));
    key = 2'b11;
    step(3);
    check("rst_no_partial_tick", hex_all, exp_hex(24'h000000));
    step(1);
    check("rst_first_tick", hex_all, exp_hex(24'h000001));

    // Count to 42 for the display pattern check.
    step(164);
    check("count_42", hex_all, exp_hex(24'h000042));
    check("ledr_count42", ledr, 10'h242);

    // Hold: prescaler and count freeze; LEDR[8] follows SW[1].
    sw = 10'b0000_0000_10;
    step(12);
    check("hold_count", hex_all, exp_hex(24'h000042));
    check("ledr_hold", ledr, 10'h142);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
